// File: rtl/rf_wb_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// fewcore_rf_pkg
// Shared constants and types for the register-file write-back scheduler.
//   XLEN        : data width of a register-file write
//   AMOUNT      : number of architectural registers
//   ADDRESSLEN  : register index width (may address past AMOUNT)
//   req_id_e    : write-back requester identity, also used as grant index
//   REG_ZERO    : hard-wired zero register index
// ---------------------------------------------------------------------------
package fewcore_rf_pkg;

   localparam int XLEN       = 32;
   localparam int AMOUNT     = 16;
   localparam int ADDRESSLEN = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LD  = 1'b1
   } req_id_e;

   localparam logic [ADDRESSLEN-1:0] REG_ZERO = '0;

   // Register 0 never carries a pending write, so its scoreboard bit is masked.
   localparam logic [AMOUNT-1:0] PEND_MASK = {{(AMOUNT-1){1'b1}}, 1'b0};

   // True when idx names an architectural register (including x0).
   function automatic logic in_range(input logic [ADDRESSLEN-1:0] idx);
      return int'(idx) < AMOUNT;
   endfunction

   // True when a write to idx must actually reach the register file.
   function automatic logic rd_writable(input logic [ADDRESSLEN-1:0] idx);
      return (idx != REG_ZERO) && in_range(idx);
   endfunction

endpackage : fewcore_rf_pkg

// File: rtl/rf_wb_scheduler_if.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler_if
// Bundles the issue, hazard, write-back and register-file signals of the
// write-back scheduler.
//   slave  : seen by the scheduler (requests in, readies/rf write out)
//   master : seen by the surrounding pipeline / bench
// Signals:
//   iss_valid/iss_rd/iss_ready     issue of an instruction writing iss_rd
//   rs1/rs2/raw_stall              source operands and RAW hazard flag
//   alu_valid/alu_rd/alu_data/alu_ready   ALU write-back request
//   ld_valid/ld_rd/ld_data/ld_ready       load write-back request
//   flush                          clears the pending-write scoreboard
//   rf_wen/rf_rd/rf_data           registered register-file write port
//   idle                           no pending writes
//   err_oob                        sticky out-of-range index seen
// ---------------------------------------------------------------------------
interface rf_wb_scheduler_if
   import fewcore_rf_pkg::*;
   ();

   logic                  iss_valid;
   logic [ADDRESSLEN-1:0] iss_rd;
   logic                  iss_ready;
   logic [ADDRESSLEN-1:0] rs1;
   logic [ADDRESSLEN-1:0] rs2;
   logic                  raw_stall;
   logic                  alu_valid;
   logic [ADDRESSLEN-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic                  alu_ready;
   logic                  ld_valid;
   logic [ADDRESSLEN-1:0] ld_rd;
   logic [XLEN-1:0]       ld_data;
   logic                  ld_ready;
   logic                  flush;
   logic                  rf_wen;
   logic [ADDRESSLEN-1:0] rf_rd;
   logic [XLEN-1:0]       rf_data;
   logic                  idle;
   logic                  err_oob;

   modport slave (
      input  iss_valid, iss_rd, rs1, rs2,
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data, flush,
      output iss_ready, raw_stall, alu_ready, ld_ready,
      output rf_wen, rf_rd, rf_data, idle, err_oob
   );

   modport master (
      output iss_valid, iss_rd, rs1, rs2,
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data, flush,
      input  iss_ready, raw_stall, alu_ready, ld_ready,
      input  rf_wen, rf_rd, rf_data, idle, err_oob
   );

endinterface : rf_wb_scheduler_if

// File: rtl/rf_wb_scheduler_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter. A lone requester is always granted; under
// contention the requester that lost the previous contention wins. The
// priority pointer only moves on contended grants.
//   clk   : clock
//   reset : synchronous, active-low; pointer returns to ALU-first
//   req   : request vector, indexed by req_id_e
//   gnt   : grant vector, one-hot or zero
// ---------------------------------------------------------------------------
module rr_arbiter2
   import fewcore_rf_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_id_e ptr_q;
   req_id_e ptr_d;

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      case (req)
         2'b01: gnt[REQ_ALU] = 1'b1;
         2'b10: gnt[REQ_LD]  = 1'b1;
         2'b11: begin
            // Winner takes the grant, the loser gets priority next time.
            if (ptr_q == REQ_ALU) begin
               gnt[REQ_ALU] = 1'b1;
               ptr_d        = REQ_LD;
            end else begin
               gnt[REQ_LD]  = 1'b1;
               ptr_d        = REQ_ALU;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q <= REQ_ALU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule : rr_arbiter2

// File: rtl/rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// rf_wb_scheduler
// Owns the single write port of the register file. Arbitrates ALU and load
// write-backs round-robin, registers the winning write, filters writes to x0
// and out-of-range indices, and keeps a pending-write scoreboard that blocks
// WAW issue and reports RAW hazards on rs1/rs2.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : rf_wb_scheduler_if.slave (issue, hazard, write-back, rf port)
// ---------------------------------------------------------------------------
module rf_wb_scheduler
   import fewcore_rf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   rf_wb_scheduler_if.slave  bus
);

   logic [1:0]            arb_req;
   logic [1:0]            arb_gnt;
   logic                  wb_fire;
   logic [ADDRESSLEN-1:0] wb_rd;
   logic [XLEN-1:0]       wb_data;
   logic                  iss_accept;

   logic [AMOUNT-1:0]     iss_dec;
   logic [AMOUNT-1:0]     wb_dec;
   logic [AMOUNT-1:0]     rs1_dec;
   logic [AMOUNT-1:0]     rs2_dec;

   logic [AMOUNT-1:0]     pending_q;
   logic [AMOUNT-1:0]     pending_d;
   logic                  err_oob_q;
   logic                  err_oob_d;
   logic                  rf_wen_q;
   logic                  rf_wen_d;
   logic [ADDRESSLEN-1:0] rf_rd_q;
   logic [ADDRESSLEN-1:0] rf_rd_d;
   logic [XLEN-1:0]       rf_data_q;
   logic [XLEN-1:0]       rf_data_d;

   // Requests are masked while in reset so no grant or ready escapes.
   assign arb_req = {bus.ld_valid, bus.alu_valid} & {2{reset}};

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (arb_req),
      .gnt   (arb_gnt)
   );

   assign bus.alu_ready = arb_gnt[REQ_ALU];
   assign bus.ld_ready  = arb_gnt[REQ_LD];

   assign wb_fire = |arb_gnt;
   assign wb_rd   = arb_gnt[REQ_LD] ? bus.ld_rd   : bus.alu_rd;
   assign wb_data = arb_gnt[REQ_LD] ? bus.ld_data : bus.alu_data;

   // One-hot decoders; an index >= AMOUNT decodes to all zeros, so it can
   // never hit the scoreboard.
   for (genvar gi = 0; gi < AMOUNT; gi++) begin : g_dec
      assign iss_dec[gi] = (bus.iss_rd == ADDRESSLEN'(gi));
      assign wb_dec[gi]  = (wb_rd      == ADDRESSLEN'(gi));
      assign rs1_dec[gi] = (bus.rs1    == ADDRESSLEN'(gi));
      assign rs2_dec[gi] = (bus.rs2    == ADDRESSLEN'(gi));
   end

   assign bus.iss_ready = reset && !(|(iss_dec & pending_q));
   assign iss_accept    = bus.iss_valid && bus.iss_ready;
   assign bus.raw_stall = |((rs1_dec | rs2_dec) & pending_q);
   assign bus.idle      = !reset || (pending_q == '0);

   // Write-back clears at the grant edge, so the hazard drops the same cycle
   // rf_wen rises. Flush wins over a same-cycle issue.
   always_comb begin
      pending_d = (pending_q & ~(wb_dec & {AMOUNT{wb_fire}}))
                | (iss_dec & {AMOUNT{iss_accept}});
      pending_d = pending_d & PEND_MASK;
      if (bus.flush) begin
         pending_d = '0;
      end
   end

   always_comb begin
      err_oob_d = err_oob_q;
      if ((iss_accept && !in_range(bus.iss_rd)) || (wb_fire && !in_range(wb_rd))) begin
         err_oob_d = 1'b1;
      end
   end

   // Filtered writes (x0, out of range) are consumed without touching the
   // register-file port; rf_rd/rf_data keep the last real write.
   always_comb begin
      rf_wen_d  = wb_fire && rd_writable(wb_rd);
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
      if (rf_wen_d) begin
         rf_rd_d   = wb_rd;
         rf_data_d = wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_q <= '0;
         err_oob_q <= 1'b0;
         rf_wen_q  <= 1'b0;
         rf_rd_q   <= '0;
         rf_data_q <= '0;
      end else begin
         pending_q <= pending_d;
         err_oob_q <= err_oob_d;
         rf_wen_q  <= rf_wen_d;
         rf_rd_q   <= rf_rd_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign bus.rf_wen  = rf_wen_q;
   assign bus.rf_rd   = rf_rd_q;
   assign bus.rf_data = rf_data_q;
   assign bus.err_oob = err_oob_q;

endmodule : rf_wb_scheduler

// File: tb/tb_rf_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_scheduler
// Directed, table-driven bench for rf_wb_scheduler. Each vector is one clock
// cycle: inputs are driven on the falling edge, then combinational outputs
// (for this cycle's inputs) and registered outputs (from earlier edges) are
// compared before the next rising edge.
// ---------------------------------------------------------------------------
module tb_rf_wb_scheduler;
   import fewcore_rf_pkg::*;

   typedef struct {
      // inputs
      logic        rst_n;
      logic        iv;
      logic [4:0]  ird;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldat;
      logic        fl;
      // expected outputs
      logic        e_ir;
      logic        e_raw;
      logic        e_ar;
      logic        e_lr;
      logic        e_wen;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_idle;
      logic        e_err;
      logic        chk_state;
      logic        chk_rf;
   } vec_t;

   logic clk;
   logic reset;
   int   num_checks;
   int   num_fail;
   vec_t tbl[$];
   vec_t t;

   rf_wb_scheduler_if bus ();

   rf_wb_scheduler dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t def_vec(input logic err);
      vec_t v;
      v.rst_n = 1'b1; v.iv = 1'b0; v.ird = '0; v.rs1 = '0; v.rs2 = '0;
      v.av = 1'b0; v.ard = '0; v.adat = '0;
      v.lv = 1'b0; v.lrd = '0; v.ldat = '0; v.fl = 1'b0;
      v.e_ir = 1'b1; v.e_raw = 1'b0; v.e_ar = 1'b0; v.e_lr = 1'b0;
      v.e_wen = 1'b0; v.e_rd = '0; v.e_data = '0;
      v.e_idle = 1'b1; v.e_err = err; v.chk_state = 1'b1; v.chk_rf = 1'b0;
      return v;
   endfunction

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_fail++;
         $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      reset         = v.rst_n;
      bus.iss_valid = v.iv;   bus.iss_rd  = v.ird;
      bus.rs1       = v.rs1;  bus.rs2     = v.rs2;
      bus.alu_valid = v.av;   bus.alu_rd  = v.ard;  bus.alu_data = v.adat;
      bus.ld_valid  = v.lv;   bus.ld_rd   = v.lrd;  bus.ld_data  = v.ldat;
      bus.flush     = v.fl;
      #2;
      check("iss_ready", idx, 32'(bus.iss_ready), 32'(v.e_ir));
      check("raw_stall", idx, 32'(bus.raw_stall), 32'(v.e_raw));
      check("alu_ready", idx, 32'(bus.alu_ready), 32'(v.e_ar));
      check("ld_ready",  idx, 32'(bus.ld_ready),  32'(v.e_lr));
      check("idle",      idx, 32'(bus.idle),      32'(v.e_idle));
      if (v.chk_state) begin
         check("rf_wen",  idx, 32'(bus.rf_wen),  32'(v.e_wen));
         check("err_oob", idx, 32'(bus.err_oob), 32'(v.e_err));
      end
      if (v.chk_rf) begin
         check("rf_rd",   idx, 32'(bus.rf_rd), 32'(v.e_rd));
         check("rf_data", idx, bus.rf_data, v.e_data);
      end
      $display("vec %0d: rst=%0b iss=%0b/%0d alu=%0b/%0d ld=%0b/%0d fl=%0b -> ar=%0b lr=%0b ir=%0b raw=%0b wen=%0b rd=%0d data=%h idle=%0b err=%0b",
               idx, v.rst_n, v.iv, v.ird, v.av, v.ard, v.lv, v.lrd, v.fl,
               bus.alu_ready, bus.ld_ready, bus.iss_ready, bus.raw_stall,
               bus.rf_wen, bus.rf_rd, bus.rf_data, bus.idle, bus.err_oob);
   endtask

   initial begin
      num_checks = 0;
      num_fail   = 0;
      reset = 1'b0;
      bus.iss_valid = 1'b0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.ld_valid = 1'b0;  bus.ld_rd = '0;  bus.ld_data = '0;
      bus.flush = 1'b0;

      // ---- reset with every valid held high ----
      t = def_vec(1'b0); t.rst_n = 1'b0; t.iv = 1; t.ird = 1; t.av = 1; t.ard = 1;
      t.lv = 1; t.lrd = 2; t.e_ir = 0; t.chk_state = 0; tbl.push_back(t);      // 0
      t.chk_state = 1; tbl.push_back(t);                                       // 1
      // ---- first write after release ----
      t = def_vec(1'b0); t.av = 1; t.ard = 3; t.adat = 32'hA5; t.e_ar = 1; tbl.push_back(t);
      t = def_vec(1'b0); t.e_wen = 1; t.e_rd = 3; t.e_data = 32'hA5; t.chk_rf = 1; tbl.push_back(t);
      // ---- contention: ALU, LD, ALU, LD ----
      t = def_vec(1'b0); t.av = 1; t.ard = 5; t.adat = 32'h55; t.lv = 1; t.lrd = 6; t.ldat = 32'h66;
      t.chk_rf = 1; t.e_ar = 1; t.e_rd = 3; t.e_data = 32'hA5; tbl.push_back(t);          // 4
      t.e_ar = 0; t.e_lr = 1; t.e_wen = 1; t.e_rd = 5; t.e_data = 32'h55; tbl.push_back(t); // 5
      t.e_ar = 1; t.e_lr = 0; t.e_rd = 6; t.e_data = 32'h66; tbl.push_back(t);             // 6
      t.e_ar = 0; t.e_lr = 1; t.e_rd = 5; t.e_data = 32'h55; tbl.push_back(t);             // 7
      t = def_vec(1'b0); t.e_wen = 1; t.e_rd = 6; t.e_data = 32'h66; t.chk_rf = 1; tbl.push_back(t);
      // ---- scoreboard: issue rd=7, RAW, WAW block, load clears ----
      t = def_vec(1'b0); t.iv = 1; t.ird = 7; t.rs1 = 7; t.chk_rf = 1; t.e_rd = 6; t.e_data = 32'h66;
      tbl.push_back(t);                                                        // 9
      t = def_vec(1'b0); t.iv = 1; t.ird = 7; t.rs1 = 7; t.e_ir = 0; t.e_raw = 1; t.e_idle = 0;
      tbl.push_back(t);                                                        // 10
      t = def_vec(1'b0); t.ird = 7; t.rs1 = 7; t.lv = 1; t.lrd = 7; t.ldat = 32'h77;
      t.e_lr = 1; t.e_ir = 0; t.e_raw = 1; t.e_idle = 0; tbl.push_back(t);     // 11
      t = def_vec(1'b0); t.ird = 7; t.rs1 = 7; t.e_wen = 1; t.e_rd = 7; t.e_data = 32'h77;
      t.chk_rf = 1; tbl.push_back(t);                                          // 12
      // ---- x0 write and out-of-range write ----
      t = def_vec(1'b0); t.av = 1; t.ard = 0; t.adat = 32'hFFFF_FFFF; t.e_ar = 1;
      t.chk_rf = 1; t.e_rd = 7; t.e_data = 32'h77; tbl.push_back(t);           // 13
      t = def_vec(1'b0); tbl.push_back(t);                                     // 14
      t = def_vec(1'b0); t.av = 1; t.ard = 20; t.adat = 32'h1234; t.e_ar = 1; tbl.push_back(t);
      t = def_vec(1'b1); tbl.push_back(t);                                     // 16
      // ---- flush with a same-cycle issue ----
      t = def_vec(1'b1); t.iv = 1; t.ird = 4; tbl.push_back(t);                // 17
      t = def_vec(1'b1); t.iv = 1; t.ird = 9; t.e_idle = 0; tbl.push_back(t);  // 18
      t = def_vec(1'b1); t.iv = 1; t.ird = 2; t.fl = 1; t.rs1 = 4; t.rs2 = 9;
      t.e_raw = 1; t.e_idle = 0; tbl.push_back(t);                             // 19
      t = def_vec(1'b1); t.rs1 = 2; t.rs2 = 9; tbl.push_back(t);               // 20
      t = def_vec(1'b1); t.lv = 1; t.lrd = 9; t.ldat = 32'h99; t.e_lr = 1; tbl.push_back(t);
      t = def_vec(1'b1); t.e_wen = 1; t.e_rd = 9; t.e_data = 32'h99; t.chk_rf = 1; tbl.push_back(t);
      // ---- high-index register, oob source, set/clear of different indices ----
      t = def_vec(1'b1); t.iv = 1; t.ird = 15; tbl.push_back(t);               // 23
      t = def_vec(1'b1); t.ird = 15; t.rs1 = 31; t.e_ir = 0; t.e_idle = 0; tbl.push_back(t);
      t = def_vec(1'b1); t.av = 1; t.ard = 15; t.adat = 32'hF; t.iv = 1; t.ird = 3; t.rs2 = 15;
      t.e_ar = 1; t.e_raw = 1; t.e_idle = 0; tbl.push_back(t);                 // 25
      t = def_vec(1'b1); t.ird = 15; t.rs2 = 15; t.e_idle = 0; t.e_wen = 1; t.e_rd = 15;
      t.e_data = 32'hF; t.chk_rf = 1; tbl.push_back(t);                        // 26
      t = def_vec(1'b1); t.fl = 1; t.e_idle = 0; tbl.push_back(t);             // 27
      t = def_vec(1'b1); tbl.push_back(t);                                     // 28

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], i);
      end

      // ---- mid-operation reset: drop a grant and restore ALU-first ----
      // Contention with the pointer at ALU-first: ALU wins, LD gets priority.
      t = def_vec(1'b1); t.av = 1; t.ard = 10; t.adat = 32'hAA; t.lv = 1; t.lrd = 11;
      t.ldat = 32'hBB; t.e_ar = 1; run_vec(t, 100);
      // Reset on the same edge as an ALU request: no grant, no write.
      t = def_vec(1'b1); t.rst_n = 0; t.av = 1; t.ard = 8; t.adat = 32'h88;
      t.e_ir = 0; t.e_wen = 1; t.e_rd = 10; t.e_data = 32'hAA; t.chk_rf = 1; run_vec(t, 101);
      // After reset the pointer is ALU-first again and err_oob is cleared.
      t = def_vec(1'b0); t.av = 1; t.ard = 8; t.adat = 32'h88; t.lv = 1; t.lrd = 11;
      t.ldat = 32'hBB; t.e_ar = 1; t.chk_rf = 1; t.e_rd = 0; t.e_data = 0; run_vec(t, 102);
      t = def_vec(1'b0); t.e_wen = 1; t.e_rd = 8; t.e_data = 32'h88; t.chk_rf = 1; run_vec(t, 103);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule : tb_rf_wb_scheduler
